// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative signed Booth multiply / restoring divide owning HI/LO
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] acc, m_x, bsum, acc_n, r, t, rem_n;
  logic [WIDTH-1:0] q, m, q_n, quo_n;
  logic q1, sa, sb, ge, last;
  // acc is one bit wider than an operand so that +/- of the most negative value cannot overflow
  always_comb begin
    m_x   = {m[WIDTH-1], m};
    bsum  = (q[0] & ~q1) ? acc - m_x : (~q[0] & q1) ? acc + m_x : acc;
    acc_n = {bsum[WIDTH], bsum[WIDTH:1]};
    q_n   = {bsum[0], q[WIDTH-1:1]};
    r     = {acc[WIDTH-1:0], q[WIDTH-1]};
    t     = r - {1'b0, m};
    ge    = ~t[WIDTH];
    rem_n = ge ? t : r;
    quo_n = {q[WIDTH-2:0], ge};
    last  = cnt == CW'(WIDTH - 1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      div_zero <= 1'b0;
      hi <= '0;
      lo <= '0;
      cnt <= '0;
      acc <= '0;
      q <= '0;
      m <= '0;
      q1 <= 1'b0;
      sa <= 1'b0;
      sb <= 1'b0;
    end else begin
      done <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          acc <= '0;
          q1 <= 1'b0;
          if (start_mult) begin
            state <= MULT;
            busy <= 1'b1;
            m <= a;
            q <= b;
          end else if (start_div && b == '0) begin
            state <= DONE;
            done <= 1'b1;
            div_zero <= 1'b1;
          end else if (start_div) begin
            state <= DIV;
            busy <= 1'b1;
            m <= b[WIDTH-1] ? -b : b;
            q <= a[WIDTH-1] ? -a : a;
            sa <= a[WIDTH-1];
            sb <= b[WIDTH-1];
          end
        end
        MULT: begin
          acc <= acc_n;
          q <= q_n;
          q1 <= q[0];
          cnt <= cnt + 1'b1;
          if (last) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
            hi <= acc_n[WIDTH-1:0];
            lo <= q_n;
          end
        end
        DIV: begin
          acc <= rem_n;
          q <= quo_n;
          cnt <= cnt + 1'b1;
          if (last) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
            hi <= sa ? -rem_n[WIDTH-1:0] : rem_n[WIDTH-1:0];
            lo <= (sa ^ sb) ? -quo_n : quo_n;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed and random checks against an arithmetic HI/LO model
module tb_muldiv_sequencer;
  logic clk = 0, reset = 1, start_mult = 0, start_div = 0;
  logic [31:0] a = 0, b = 0, hi, lo;
  logic busy, done, div_zero;
  logic [31:0] exp_hi = 0, exp_lo = 0;
  int checks = 0, fails = 0;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start_mult(start_mult), .start_div(start_div),
    .a(a), .b(b), .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic do_op(input logic sm, input logic sd, input logic [31:0] av, input logic [31:0] bv, input int inj);
    longint p, qq, rr;
    int n, nb;
    logic dz;
    dz = !sm && bv == 0;
    @(negedge clk);
    start_mult = sm; start_div = sd; a = av; b = bv;
    @(negedge clk);
    start_mult = 0; start_div = 0; a = $urandom; b = $urandom;
    n = 1; nb = 0;
    while (!done && n < 40) begin
      if (busy) nb++;
      chk("hold_hi", hi, exp_hi);
      chk("hold_lo", lo, exp_lo);
      if (n == inj) start_div = 1;
      @(negedge clk);
      start_div = 0;
      n++;
    end
    chk("latency", n, dz ? 1 : 33);
    chk("busy_cycles", nb, dz ? 0 : 32);
    if (sm) begin
      p = longint'($signed(av)) * longint'($signed(bv));
      exp_hi = p[63:32]; exp_lo = p[31:0];
    end else if (!dz) begin
      qq = longint'($signed(av)) / longint'($signed(bv));
      rr = longint'($signed(av)) % longint'($signed(bv));
      exp_hi = rr[31:0]; exp_lo = qq[31:0];
    end
    chk("done_busy", busy, 0);
    chk("div_zero", div_zero, dz);
    chk("hi", hi, exp_hi);
    chk("lo", lo, exp_lo);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("done_after", {done, div_zero, busy}, 0);
    end
  endtask

  initial begin
    int nd;
    logic sm, sd;
    logic [31:0] av, bv;
    repeat (3) @(negedge clk);
    reset = 0;
    chk("rst_flags", {busy, done, div_zero}, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    do_op(1, 0, 32'd7, -32'sd3, 0);
    chk("t1_hi", hi, 32'hFFFFFFFF);
    chk("t1_lo", lo, 32'hFFFFFFEB);
    do_op(1, 0, 32'h80000000, 32'h80000000, 0);
    chk("t2_hi", hi, 32'h40000000);
    chk("t2_lo", lo, 32'h0);
    do_op(0, 1, -32'sd7, 32'd2, 0);
    chk("t3a_lo", lo, 32'hFFFFFFFD);
    chk("t3a_hi", hi, 32'hFFFFFFFF);
    do_op(0, 1, 32'd7, -32'sd2, 0);
    chk("t3b_lo", lo, 32'hFFFFFFFD);
    chk("t3b_hi", hi, 32'h1);
    do_op(0, 1, 32'd5, 32'd0, 0);
    chk("t4_hi", hi, 32'h1);
    chk("t4_lo", lo, 32'hFFFFFFFD);
    do_op(1, 1, 32'd3, 32'd4, 10);
    chk("t5_lo", lo, 32'd12);
    chk("t5_hi", hi, 32'd0);
    do_op(0, 1, 32'h80000000, 32'hFFFFFFFF, 0);
    chk("ovf_lo", lo, 32'h80000000);
    chk("ovf_hi", hi, 32'h0);
    // reset in the middle of a divide discards it
    @(negedge clk);
    start_div = 1; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start_div = 0;
    repeat (14) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_hi", hi, 0);
    chk("t6_lo", lo, 0);
    exp_hi = 0; exp_lo = 0;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("t6_no_done", nd, 0);
    do_op(1, 0, 32'd2, 32'd2, 0);
    chk("t6_lo4", lo, 32'd4);
    for (int i = 0; i < 24; i++) begin
      sm = $urandom_range(0, 2) != 1;
      sd = !sm || $urandom_range(0, 1) == 1;
      av = $urandom_range(0, 7) == 0 ? 32'h80000000 : $urandom;
      bv = $urandom_range(0, 6) == 0 ? 32'h0 : $urandom_range(0, 5) == 0 ? 32'hFFFFFFFF : $urandom;
      do_op(sm, sd, av, bv, $urandom_range(0, 3) == 0 ? int'($urandom_range(1, 31)) : 0);
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
